// File: rtl/dht11_controller.sv
// DHT11 single-wire sensor controller.
// Sends the host start pulse, times the sensor response and the 40 data bits,
// and registers the integer humidity/temperature bytes on a good frame.
// Optional build macro DHT11_CHECKSUM_EN: when defined, a frame whose checksum
// byte does not match raises err instead of updating humid/temp. When it is not
// defined, every complete frame is accepted.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | line released, waiting for start
// START   | host holds the line low for START_LOW_US
// WAIT    | line released, waiting for the sensor to pull low
// RESP_L  | sensor response low phase, waiting for rise
// RESP_H  | sensor response high phase, waiting for fall
// BIT_L   | data bit low phase, waiting for rise
// BIT_H   | data bit high phase; its length decides the bit value
// CHECK   | full frame captured, verify and load outputs
// ERR     | one-cycle error pulse, then back to IDLE
module dht11_controller #(
  parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
  parameter int unsigned START_LOW_US = 18000,
  parameter int unsigned TIMEOUT_US   = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  inout  wire        dht_io,
  output logic [7:0] humid,
  output logic [7:0] temp,
  output logic       valid,
  output logic       busy,
  output logic       err
);

  localparam int unsigned CYC_PER_US = CLK_FREQ_HZ / 1_000_000;
  localparam int unsigned PW         = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CYC_PER_US - 1);
  localparam logic [14:0]   START_CNT  = 15'(START_LOW_US);
  localparam logic [14:0]   TO_CNT     = 15'(TIMEOUT_US);
  localparam logic [14:0]   ONE_THRESH = 15'd40;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_WAIT, S_RESP_L, S_RESP_H,
    S_BIT_L, S_BIT_H, S_CHECK, S_ERR
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [14:0]   us_cnt_q, us_cnt_d;
  logic [1:0]    sync_q;
  logic          din_prev_q;
  logic [39:0]   shift_q, shift_d;
  logic [5:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    humid_q, humid_d;
  logic [7:0]    temp_q, temp_d;
  logic          valid_q, valid_d;
  logic          oe_q;

  logic din, rise, fall, tick, state_chg, timeout;

  // Open-drain: only ever pull low, otherwise let the board pull-up win.
  assign dht_io = oe_q ? 1'b0 : 1'bz;

  assign din       = sync_q[1];
  assign rise      = din & ~din_prev_q;
  assign fall      = ~din & din_prev_q;
  assign tick      = (presc_q == PRESC_LAST);
  assign state_chg = (state_d != state_q);
  assign timeout   = (us_cnt_q > TO_CNT);

`ifdef DHT11_CHECKSUM_EN
  logic [7:0] sum_calc;
  assign sum_calc = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];
`endif

  // Prescaler and microsecond counter both restart on every state change so
  // each state measures its own dwell time from zero.
  always_comb begin
    presc_d  = presc_q;
    us_cnt_d = us_cnt_q;
    if (state_chg) begin
      presc_d  = '0;
      us_cnt_d = '0;
    end else if (tick) begin
      presc_d  = '0;
      us_cnt_d = us_cnt_q + 15'd1;
    end else begin
      presc_d  = presc_q + PW'(1);
    end
  end

  // Next-state, frame capture and output load decisions.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    humid_d   = humid_q;
    temp_d    = temp_q;
    valid_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_START;
      end
      S_START: begin
        if (us_cnt_q == START_CNT) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (fall)         state_d = S_RESP_L;
        else if (timeout) state_d = S_ERR;
      end
      S_RESP_L: begin
        if (rise)         state_d = S_RESP_H;
        else if (timeout) state_d = S_ERR;
      end
      S_RESP_H: begin
        if (fall) begin
          state_d   = S_BIT_L;
          bit_idx_d = '0;
        end else if (timeout) begin
          state_d = S_ERR;
        end
      end
      S_BIT_L: begin
        if (rise)         state_d = S_BIT_H;
        else if (timeout) state_d = S_ERR;
      end
      S_BIT_H: begin
        if (fall) begin
          // Long high phase means a 1; bits arrive MSB first.
          shift_d = {shift_q[38:0], (us_cnt_q > ONE_THRESH)};
          if (bit_idx_q == 6'd39) begin
            state_d = S_CHECK;
          end else begin
            bit_idx_d = bit_idx_q + 6'd1;
            state_d   = S_BIT_L;
          end
        end else if (timeout) begin
          state_d = S_ERR;
        end
      end
      S_CHECK: begin
`ifdef DHT11_CHECKSUM_EN
        if (sum_calc == shift_q[7:0]) begin
          humid_d = shift_q[39:32];
          temp_d  = shift_q[23:16];
          valid_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_ERR;
        end
`else
        humid_d = shift_q[39:32];
        temp_d  = shift_q[23:16];
        valid_d = 1'b1;
        state_d = S_IDLE;
`endif
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters, synchronizer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      us_cnt_q   <= '0;
      sync_q     <= 2'b11;
      din_prev_q <= 1'b1;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      humid_q    <= '0;
      temp_q     <= '0;
      valid_q    <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      us_cnt_q   <= us_cnt_d;
      sync_q     <= {sync_q[0], dht_io};
      din_prev_q <= din;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      humid_q    <= humid_d;
      temp_q     <= temp_d;
      valid_q    <= valid_d;
      // Registered from the next state so the pin changes with the state.
      oe_q       <= (state_d == S_START);
    end
  end

  assign humid = humid_q;
  assign temp  = temp_q;
  assign valid = valid_q;
  assign busy  = (state_q != S_IDLE);
  assign err   = (state_q == S_ERR);

endmodule
